// File: rtl/perf_fpga_complicated_pkg.sv
// Shared types and widths for the vFPGA benchmark engine.
// Field widths mirror the lynxTypes definitions used by the rest of the shell.
package perf_fpga_complicated_pkg;

  localparam int unsigned LEN_BITS   = 28;
  localparam int unsigned VADDR_BITS = 48;
  localparam int unsigned PID_BITS   = 6;

  localparam int unsigned MAX_OUTSTANDING_DEF = 8;

  localparam int unsigned CTRL_RD = 0;
  localparam int unsigned CTRL_WR = 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } bench_state_e;

endpackage

// File: rtl/perf_fpga_bench_dir_issuer.sv
// One request direction: valid/ready issue, issued/completed tracking with an in-flight cap,
// and the per-direction done flags used by the engine FSM.
module perf_fpga_bench_dir_issuer
  import perf_fpga_complicated_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned CNT_BITS        = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                soft_reset,
  input  logic                start,
  input  logic                start_en,
  input  logic [CNT_BITS-1:0] start_reps,
  input  logic                active,
  input  logic                sq_ready,
  output logic                sq_valid,
  input  logic                cq_valid,
  output logic [CNT_BITS-1:0] completed,
  output logic                issue_done,
  output logic                comp_done
);

  localparam logic [CNT_BITS-1:0] MaxOut = CNT_BITS'(MAX_OUTSTANDING);

  logic                en_q;
  logic                valid_q;
  logic [CNT_BITS-1:0] n_reps_q;
  logic [CNT_BITS-1:0] issued_q, issued_d;
  logic [CNT_BITS-1:0] completed_q, completed_d;
  logic                fire;
  logic                cq_take;

  always_comb begin
    fire        = valid_q && sq_ready;
    // Completions saturate at n_reps and never run ahead of what was issued.
    cq_take     = active && cq_valid && (completed_q < n_reps_q) && (completed_q < issued_q);
    issued_d    = issued_q + CNT_BITS'(fire);
    completed_d = completed_q + CNT_BITS'(cq_take);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || soft_reset) begin
      en_q        <= 1'b0;
      valid_q     <= 1'b0;
      n_reps_q    <= '0;
      issued_q    <= '0;
      completed_q <= '0;
    end else if (start) begin
      en_q        <= start_en;
      valid_q     <= start_en && (start_reps != '0);
      n_reps_q    <= start_reps;
      issued_q    <= '0;
      completed_q <= '0;
    end else begin
      issued_q    <= issued_d;
      completed_q <= completed_d;
      // Only a handshake can push either term to its limit, so valid never drops mid-stall.
      valid_q     <= en_q && (issued_d < n_reps_q) && ((issued_d - completed_d) < MaxOut);
    end
  end

  assign sq_valid   = valid_q;
  assign completed  = completed_q;
  assign issue_done = !en_q || (issued_q == n_reps_q);
  assign comp_done  = !en_q || (completed_q == n_reps_q);

endmodule

// File: rtl/perf_fpga_complicated_bench_engine.sv
// Benchmark engine: issues rd/wr requests per parser config and counts completions and run time.
// Optional beat-count check enabled by defining BENCH_BEAT_CHECK_EN.
module perf_fpga_complicated_bench_engine
  import perf_fpga_complicated_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned CNT_BITS        = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  bench_reset,
  input  logic [31:0]           bench_n_reps,
  input  logic [1:0]            bench_req_ctrl,
  input  logic [63:0]           bench_req_n_beats,
  input  logic [LEN_BITS-1:0]   bench_req_len_A,
  input  logic [LEN_BITS-1:0]   bench_req_len_B,
  input  logic [VADDR_BITS-1:0] bench_req_vaddr_A,
  input  logic [VADDR_BITS-1:0] bench_req_vaddr_B,
  input  logic [PID_BITS-1:0]   bench_req_pid,
  output logic                  req_accepted,
  output logic [31:0]           bench_done,
  output logic [63:0]           bench_timer,
  output logic                  sq_rd_valid,
  input  logic                  sq_rd_ready,
  output logic [VADDR_BITS-1:0] sq_rd_vaddr,
  output logic [LEN_BITS-1:0]   sq_rd_len,
  output logic [PID_BITS-1:0]   sq_rd_pid,
  output logic                  sq_wr_valid,
  input  logic                  sq_wr_ready,
  output logic [VADDR_BITS-1:0] sq_wr_vaddr,
  output logic [LEN_BITS-1:0]   sq_wr_len,
  output logic [PID_BITS-1:0]   sq_wr_pid,
  input  logic                  cq_rd_valid,
  input  logic                  cq_wr_valid,
  input  logic                  mon_valid,
  input  logic                  mon_ready,
  output logic                  beat_err
);

  bench_state_e          state_q;
  logic [1:0]            ctrl_q;
  logic [LEN_BITS-1:0]   len_a_q, len_b_q;
  logic [VADDR_BITS-1:0] vaddr_a_q, vaddr_b_q;
  logic [PID_BITS-1:0]   pid_q;
  logic                  req_accepted_q;
  logic [63:0]           timer_q;

  logic                  start;
  logic                  active;
  logic                  drain_exit;
  logic                  rd_issue_done, wr_issue_done;
  logic                  rd_comp_done, wr_comp_done;
  logic [CNT_BITS-1:0]   rd_completed, wr_completed;
  logic [CNT_BITS-1:0]   done_sel;

  assign start      = (state_q == StIdle) && (bench_req_ctrl != 2'b00);
  assign active     = (state_q == StIssue) || (state_q == StDrain);
  assign drain_exit = (state_q == StDrain) && rd_comp_done && wr_comp_done;

  perf_fpga_bench_dir_issuer #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_BITS        (CNT_BITS)
  ) u_rd_issuer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .soft_reset (bench_reset),
    .start      (start),
    .start_en   (bench_req_ctrl[CTRL_RD]),
    .start_reps (CNT_BITS'(bench_n_reps)),
    .active     (active),
    .sq_ready   (sq_rd_ready),
    .sq_valid   (sq_rd_valid),
    .cq_valid   (cq_rd_valid),
    .completed  (rd_completed),
    .issue_done (rd_issue_done),
    .comp_done  (rd_comp_done)
  );

  perf_fpga_bench_dir_issuer #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_BITS        (CNT_BITS)
  ) u_wr_issuer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .soft_reset (bench_reset),
    .start      (start),
    .start_en   (bench_req_ctrl[CTRL_WR]),
    .start_reps (CNT_BITS'(bench_n_reps)),
    .active     (active),
    .sq_ready   (sq_wr_ready),
    .sq_valid   (sq_wr_valid),
    .cq_valid   (cq_wr_valid),
    .completed  (wr_completed),
    .issue_done (wr_issue_done),
    .comp_done  (wr_comp_done)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn || bench_reset) begin
      state_q        <= StIdle;
      ctrl_q         <= '0;
      len_a_q        <= '0;
      len_b_q        <= '0;
      vaddr_a_q      <= '0;
      vaddr_b_q      <= '0;
      pid_q          <= '0;
      req_accepted_q <= 1'b0;
      timer_q        <= '0;
    end else begin
      req_accepted_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ctrl_q         <= bench_req_ctrl;
            len_a_q        <= bench_req_len_A;
            len_b_q        <= bench_req_len_B;
            vaddr_a_q      <= bench_req_vaddr_A;
            vaddr_b_q      <= bench_req_vaddr_B;
            pid_q          <= bench_req_pid;
            req_accepted_q <= 1'b1;
            timer_q        <= '0;
            state_q        <= (bench_n_reps == '0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          timer_q <= timer_q + 64'd1;
          if (rd_issue_done && wr_issue_done) state_q <= StDrain;
        end
        StDrain: begin
          timer_q <= timer_q + 64'd1;
          if (drain_exit) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // With both directions running, a rep counts as done only once both halves completed.
  always_comb begin
    done_sel = '0;
    unique case (ctrl_q)
      2'b01:   done_sel = rd_completed;
      2'b10:   done_sel = wr_completed;
      2'b11:   done_sel = (rd_completed < wr_completed) ? rd_completed : wr_completed;
      default: done_sel = '0;
    endcase
  end

  assign req_accepted = req_accepted_q;
  assign bench_done   = 32'(done_sel);
  assign bench_timer  = timer_q;
  assign sq_rd_vaddr  = vaddr_a_q;
  assign sq_rd_len    = len_a_q;
  assign sq_rd_pid    = pid_q;
  assign sq_wr_vaddr  = vaddr_b_q;
  assign sq_wr_len    = len_b_q;
  assign sq_wr_pid    = pid_q;

`ifdef BENCH_BEAT_CHECK_EN
  logic [63:0] beat_cnt_q, beat_cnt_d;
  logic [63:0] n_beats_q;
  logic        beat_err_q;

  assign beat_cnt_d = beat_cnt_q + 64'(active && mon_valid && mon_ready);

  always_ff @(posedge aclk) begin
    if (!aresetn || bench_reset) begin
      beat_cnt_q <= '0;
      n_beats_q  <= '0;
      beat_err_q <= 1'b0;
    end else if (start) begin
      beat_cnt_q <= '0;
      n_beats_q  <= bench_req_n_beats;
      // A zero-rep run enters DONE directly with no beats seen.
      beat_err_q <= (bench_n_reps == '0) && (bench_req_n_beats != '0);
    end else begin
      beat_cnt_q <= beat_cnt_d;
      if (drain_exit) beat_err_q <= (beat_cnt_d != n_beats_q);
    end
  end

  assign beat_err = beat_err_q;
`else
  logic unused_beat_inputs;
  assign unused_beat_inputs = ^{mon_valid, mon_ready, bench_req_n_beats};
  assign beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_perf_fpga_complicated_bench_engine.sv
// Randomized self-checking bench for the benchmark engine; a completion BFM answers issues.
// Define BENCH_BEAT_CHECK_EN to also exercise the beat-count check.
module tb_perf_fpga_complicated_bench_engine;
  import perf_fpga_complicated_pkg::*;

  localparam int unsigned MaxOut = 8;
  localparam int unsigned Big    = 32'h4000_0000;

  logic                  aclk = 1'b0;
  logic                  aresetn, bench_reset;
  logic [31:0]           bench_n_reps;
  logic [1:0]            bench_req_ctrl;
  logic [63:0]           bench_req_n_beats;
  logic [LEN_BITS-1:0]   len_a, len_b;
  logic [VADDR_BITS-1:0] vaddr_a, vaddr_b;
  logic [PID_BITS-1:0]   pid;
  logic                  req_accepted;
  logic [31:0]           bench_done;
  logic [63:0]           bench_timer;
  logic                  sq_rd_valid, sq_rd_ready, sq_wr_valid, sq_wr_ready;
  logic [VADDR_BITS-1:0] sq_rd_vaddr, sq_wr_vaddr;
  logic [LEN_BITS-1:0]   sq_rd_len, sq_wr_len;
  logic [PID_BITS-1:0]   sq_rd_pid, sq_wr_pid;
  logic                  cq_rd_valid, cq_wr_valid, mon_valid, mon_ready, beat_err;

  perf_fpga_complicated_bench_engine #(
    .MAX_OUTSTANDING (MaxOut),
    .CNT_BITS        (32)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .bench_reset       (bench_reset),
    .bench_n_reps      (bench_n_reps),
    .bench_req_ctrl    (bench_req_ctrl),
    .bench_req_n_beats (bench_req_n_beats),
    .bench_req_len_A   (len_a),
    .bench_req_len_B   (len_b),
    .bench_req_vaddr_A (vaddr_a),
    .bench_req_vaddr_B (vaddr_b),
    .bench_req_pid     (pid),
    .req_accepted      (req_accepted),
    .bench_done        (bench_done),
    .bench_timer       (bench_timer),
    .sq_rd_valid       (sq_rd_valid),
    .sq_rd_ready       (sq_rd_ready),
    .sq_rd_vaddr       (sq_rd_vaddr),
    .sq_rd_len         (sq_rd_len),
    .sq_rd_pid         (sq_rd_pid),
    .sq_wr_valid       (sq_wr_valid),
    .sq_wr_ready       (sq_wr_ready),
    .sq_wr_vaddr       (sq_wr_vaddr),
    .sq_wr_len         (sq_wr_len),
    .sq_wr_pid         (sq_wr_pid),
    .cq_rd_valid       (cq_rd_valid),
    .cq_wr_valid       (cq_wr_valid),
    .mon_valid         (mon_valid),
    .mon_ready         (mon_ready),
    .beat_err          (beat_err)
  );

  always #5 aclk = ~aclk;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int start_cycle;
  int rd_hs, wr_hs, rd_cq_cnt, wr_cq_cnt, rd_cq_vis, wr_cq_vis;
  int rd_cq_limit = 0, wr_cq_limit = 0, last_rd_cq, last_wr_cq;
  int cq_delay = 3;
  bit wr_rand_ready = 1'b0;
  int rd_due[$];
  int wr_due[$];

  // Completion BFM: answers each observed handshake cq_delay cycles later, subject to a limit.
  initial begin
    cq_rd_valid = 1'b0;
    cq_wr_valid = 1'b0;
    forever begin
      @(negedge aclk);
      cycle++;
      rd_cq_vis = rd_cq_cnt;
      wr_cq_vis = wr_cq_cnt;
      if (wr_rand_ready) sq_wr_ready = 1'($urandom_range(0, 1));
      cq_rd_valid = 1'b0;
      cq_wr_valid = 1'b0;
      if (rd_due.size() > 0 && rd_due[0] <= cycle && rd_cq_cnt < rd_cq_limit) begin
        void'(rd_due.pop_front());
        cq_rd_valid = 1'b1;
        rd_cq_cnt++;
        last_rd_cq = cycle;
      end
      if (wr_due.size() > 0 && wr_due[0] <= cycle && wr_cq_cnt < wr_cq_limit) begin
        void'(wr_due.pop_front());
        cq_wr_valid = 1'b1;
        wr_cq_cnt++;
        last_wr_cq = cycle;
      end
      if (sq_rd_valid && sq_rd_ready) begin
        rd_hs++;
        rd_due.push_back(cycle + cq_delay);
      end
      if (sq_wr_valid && sq_wr_ready) begin
        wr_hs++;
        wr_due.push_back(cycle + cq_delay);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      #1;
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic randomize_fields();
    len_a   = LEN_BITS'($urandom);
    len_b   = LEN_BITS'($urandom);
    vaddr_a = VADDR_BITS'({$urandom, $urandom});
    vaddr_b = VADDR_BITS'({$urandom, $urandom});
    pid     = PID_BITS'($urandom);
  endtask

  task automatic start_run(input logic [1:0] c, input int unsigned reps, input longint beats,
                           input int rd_lim, input int wr_lim);
    for (int i = 0; i < 200 && (rd_due.size() > 0 || wr_due.size() > 0); i++) tick();
    tick(2);
    rd_hs = 0; wr_hs = 0; rd_cq_cnt = 0; wr_cq_cnt = 0;
    rd_cq_limit = rd_lim;
    wr_cq_limit = wr_lim;
    bench_req_ctrl    = c;
    bench_n_reps      = reps;
    bench_req_n_beats = beats;
    start_cycle       = cycle;
    tick();
    bench_req_ctrl    = 2'b00;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; bench_reset = 1'b0; bench_req_ctrl = 2'b11; bench_n_reps = 32'd5;
    bench_req_n_beats = '0; sq_rd_ready = 1'b1; sq_wr_ready = 1'b1;
    mon_valid = 1'b0; mon_ready = 1'b0;
    randomize_fields();
    tick(4);
    tests_run++;
    if (req_accepted !== 1'b0 || sq_rd_valid !== 1'b0 || sq_wr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: got acc=%b rdv=%b wrv=%b want 0 0 0",
               req_accepted, sq_rd_valid, sq_wr_valid);
    end
    tests_run++;
    if (bench_done !== 32'd0 || bench_timer !== 64'd0 || beat_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got done=%0d timer=%0d err=%b want 0 0 0",
               bench_done, bench_timer, beat_err);
    end
    // Soft reset coinciding with a start request must win.
    aresetn = 1'b1; bench_reset = 1'b1; bench_req_ctrl = 2'b01;
    tick();
    bench_reset = 1'b0; bench_req_ctrl = 2'b00;
    tick();
    tests_run++;
    if (req_accepted !== 1'b0 || sq_rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wins: got acc=%b rdv=%b want 0 0", req_accepted, sq_rd_valid);
    end
  endtask

  task automatic test_rd_basic();
    longint exp_timer;
    randomize_fields();
    len_a = LEN_BITS'(4096);
    start_run(2'b01, 4, 0, Big, Big);
    tests_run++;
    if (req_accepted !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_accept: got %b want 1", req_accepted);
    end
    tests_run++;
    if (sq_rd_valid !== 1'b1 || sq_rd_len !== len_a || sq_rd_vaddr !== vaddr_a ||
        sq_rd_pid !== pid || sq_wr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_fields: got v=%b len=%0d va=%h pid=%0d wv=%b want 1 %0d %h %0d 0",
               sq_rd_valid, sq_rd_len, sq_rd_vaddr, sq_rd_pid, sq_wr_valid, len_a, vaddr_a, pid);
    end
    tick();
    tests_run++;
    if (req_accepted !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_accept_pulse: got %b want 0", req_accepted);
    end
    for (int i = 0; i < 200 && bench_done !== 32'd4; i++) tick();
    tick(4);
    exp_timer = longint'(last_rd_cq - start_cycle + 1);
    tests_run++;
    if (rd_hs !== 4 || wr_hs !== 0 || bench_done !== 32'd4) begin
      tests_failed++;
      $display("FAIL rd_counts: got rd=%0d wr=%0d done=%0d want 4 0 4", rd_hs, wr_hs, bench_done);
    end
    tests_run++;
    if (bench_timer !== 64'(exp_timer)) begin
      tests_failed++;
      $display("FAIL rd_timer: got %0d want %0d", bench_timer, exp_timer);
    end
    tick(5);
    tests_run++;
    if (bench_timer !== 64'(exp_timer)) begin
      tests_failed++;
      $display("FAIL rd_timer_frozen: got %0d want %0d", bench_timer, exp_timer);
    end
  endtask

  task automatic test_outstanding();
    int reps = 16;
    int exp_fly = min_i(reps, MaxOut);
    randomize_fields();
    start_run(2'b11, reps, 0, 0, 0);
    tick(30);
    tests_run++;
    if (rd_hs !== exp_fly || wr_hs !== exp_fly) begin
      tests_failed++;
      $display("FAIL out_cap: got rd=%0d wr=%0d want %0d", rd_hs, wr_hs, exp_fly);
    end
    tests_run++;
    if (sq_rd_valid !== 1'b0 || sq_wr_valid !== 1'b0 || bench_done !== 32'd0) begin
      tests_failed++;
      $display("FAIL out_stall: got rdv=%b wrv=%b done=%0d want 0 0 0",
               sq_rd_valid, sq_wr_valid, bench_done);
    end
    rd_cq_limit = Big;
    tick(80);
    tests_run++;
    if (rd_hs !== reps || wr_hs !== exp_fly) begin
      tests_failed++;
      $display("FAIL out_rd_only: got rd=%0d wr=%0d want %0d %0d", rd_hs, wr_hs, reps, exp_fly);
    end
    tests_run++;
    if (bench_done !== 32'(min_i(min_i(rd_cq_vis, reps), min_i(wr_cq_vis, reps)))) begin
      tests_failed++;
      $display("FAIL out_min: got %0d want %0d", bench_done,
               min_i(min_i(rd_cq_vis, reps), min_i(wr_cq_vis, reps)));
    end
    wr_cq_limit = Big;
    for (int i = 0; i < 300 && bench_done !== 32'(reps); i++) tick();
    tick(2);
    tests_run++;
    if (wr_hs !== reps || bench_done !== 32'(min_i(min_i(rd_cq_vis, reps), min_i(wr_cq_vis, reps))))
    begin
      tests_failed++;
      $display("FAIL out_final: got wr=%0d done=%0d want %0d %0d", wr_hs, bench_done, reps, reps);
    end
  endtask

  task automatic test_wr_random_ready();
    int reps = int'($urandom_range(6, 20));
    bit stalled = 1'b0;
    logic [LEN_BITS-1:0] p_len;
    logic [VADDR_BITS-1:0] p_va;
    logic [PID_BITS-1:0] p_pid;
    randomize_fields();
    start_run(2'b10, reps, 0, Big, Big);
    wr_rand_ready = 1'b1;
    for (int i = 0; i < 500 && bench_done !== 32'(reps); i++) begin
      if (stalled) begin
        tests_run++;
        if (sq_wr_valid !== 1'b1 || sq_wr_len !== p_len || sq_wr_vaddr !== p_va ||
            sq_wr_pid !== p_pid) begin
          tests_failed++;
          $display("FAIL wr_stable: got v=%b len=%0d va=%h pid=%0d want 1 %0d %h %0d",
                   sq_wr_valid, sq_wr_len, sq_wr_vaddr, sq_wr_pid, p_len, p_va, p_pid);
        end
      end
      if (sq_wr_valid === 1'b1) begin
        tests_run++;
        if (sq_wr_len !== len_b || sq_wr_vaddr !== vaddr_b || sq_wr_pid !== pid) begin
          tests_failed++;
          $display("FAIL wr_fields: got len=%0d va=%h pid=%0d want %0d %h %0d",
                   sq_wr_len, sq_wr_vaddr, sq_wr_pid, len_b, vaddr_b, pid);
        end
      end
      stalled = sq_wr_valid && !sq_wr_ready;
      p_len = sq_wr_len; p_va = sq_wr_vaddr; p_pid = sq_wr_pid;
      tick();
    end
    wr_rand_ready = 1'b0;
    sq_wr_ready = 1'b1;
    tick(3);
    tests_run++;
    if (wr_hs !== reps || rd_hs !== 0 || bench_done !== 32'(reps)) begin
      tests_failed++;
      $display("FAIL wr_counts: got wr=%0d rd=%0d done=%0d want %0d 0 %0d",
               wr_hs, rd_hs, bench_done, reps, reps);
    end
  endtask

  task automatic test_zero_reps();
    bit saw_valid = 1'b0;
    randomize_fields();
    start_run(2'b01, 0, 0, Big, Big);
    tests_run++;
    if (req_accepted !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_accept: got %b want 1", req_accepted);
    end
    for (int i = 0; i < 10; i++) begin
      if (sq_rd_valid === 1'b1 || sq_wr_valid === 1'b1) saw_valid = 1'b1;
      tick();
    end
    tests_run++;
    if (saw_valid || rd_hs !== 0 || bench_done !== 32'd0 || bench_timer !== 64'd0) begin
      tests_failed++;
      $display("FAIL zero_run: got valid=%b rd=%0d done=%0d timer=%0d want 0 0 0 0",
               saw_valid, rd_hs, bench_done, bench_timer);
    end
  endtask

  task automatic test_reset_mid_drain();
    randomize_fields();
    start_run(2'b01, 6, 0, 3, Big);
    tick(25);
    tests_run++;
    if (rd_hs !== 6 || bench_done !== 32'(min_i(rd_cq_vis, 6))) begin
      tests_failed++;
      $display("FAIL drain_pre: got rd=%0d done=%0d want 6 %0d", rd_hs, bench_done,
               min_i(rd_cq_vis, 6));
    end
    bench_reset = 1'b1;
    tick();
    bench_reset = 1'b0;
    rd_cq_limit = Big;
    tests_run++;
    if (bench_done !== 32'd0 || bench_timer !== 64'd0 || sq_rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_reset: got done=%0d timer=%0d v=%b want 0 0 0",
               bench_done, bench_timer, sq_rd_valid);
    end
    tick(15);
    tests_run++;
    if (bench_done !== 32'd0 || bench_timer !== 64'd0 || req_accepted !== 1'b0 || rd_hs !== 6)
    begin
      tests_failed++;
      $display("FAIL drain_late_cq: got done=%0d timer=%0d acc=%b rd=%0d want 0 0 0 6",
               bench_done, bench_timer, req_accepted, rd_hs);
    end
  endtask

  task automatic test_beat_check(input int nb);
    logic exp_err;
    randomize_fields();
    start_run(2'b01, 4, 64, Big, 0);
    rd_cq_limit = 0;
    mon_valid = 1'b1;
    mon_ready = 1'b1;
    tick(nb);
    mon_valid = 1'b0;
    rd_cq_limit = Big;
    for (int i = 0; i < 200 && bench_done !== 32'd4; i++) tick();
    tick(4);
`ifdef BENCH_BEAT_CHECK_EN
    exp_err = (nb != 64);
`else
    exp_err = 1'b0;
`endif
    tests_run++;
    if (beat_err !== exp_err || bench_done !== 32'd4) begin
      tests_failed++;
      $display("FAIL beat_%0d: got err=%b done=%0d want %b 4", nb, beat_err, bench_done, exp_err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_rd_basic();
    test_outstanding();
    test_wr_random_ready();
    test_zero_reps();
    test_reset_mid_drain();
    test_beat_check(63);
    test_beat_check(64);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/perf_fpga_complicated_bench_engine.md
Name: perf_fpga_complicated_bench_engine

Overview:
- Benchmark engine directly downstream of the vFPGA AXI-Lite control parser.
- Consumes the parser's configuration outputs (reset, reps, ctrl, lengths, vaddrs, pid) and issues read/write requests on the send queues.
- Counts completions and returns bench_done, bench_timer and req_accepted to the parser.
- Data movement itself is outside this block; it only generates requests and tracks completions.

Parameters:
- MAX_OUTSTANDING, 8, max in-flight requests per direction (rd, wr); power of two, ≥ 1.
- CNT_BITS, 32, width of rep/issue/completion counters.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- bench_reset  in  1  one-cycle soft reset pulse from parser
- bench_n_reps  in  32  reps per run
- bench_req_ctrl  in  2  bit0 = read A, bit1 = write B; nonzero = start request
- bench_req_n_beats  in  64  expected total data beats (used only with optional feature)
- bench_req_len_A / bench_req_len_B  in  LEN_BITS  request byte length
- bench_req_vaddr_A / bench_req_vaddr_B  in  VADDR_BITS  virtual address
- bench_req_pid  in  PID_BITS  process id
- req_accepted  out  1  one-cycle pulse when the run is latched
- bench_done  out  32  completed reps
- bench_timer  out  64  run cycle count
- sq_rd_valid / sq_rd_ready  out/in  1  read request handshake
- sq_rd_vaddr, sq_rd_len, sq_rd_pid  out  VADDR_BITS, LEN_BITS, PID_BITS  read request fields
- sq_wr_* same as sq_rd_*  write request channel
- cq_rd_valid / cq_wr_valid  in  1  completion pulse, one per finished request
- mon_valid / mon_ready  in  1  data-stream tap (optional feature only)
- beat_err  out  1  beat-count mismatch flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (aresetn=0 or bench_reset=1, same cycle effect):
  - state=IDLE; all counters, bench_done, bench_timer = 0.
  - req_accepted = 0, sq_*_valid = 0, beat_err = 0.
  - bench_reset wins over any simultaneous start or completion.
- FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE, bench_req_ctrl != 0:
  - Latch ctrl, n_reps, lens, vaddrs, pid, n_beats.
  - Pulse req_accepted for exactly 1 cycle.
  - Clear counters and timer.
  - Next state ISSUE, or DONE if n_reps == 0 (timer stays 0).
- IDLE, ctrl == 0: no action. Completions arriving in IDLE or DONE are dropped.
- ISSUE:
  - Each enabled direction independently drives valid with latched fields.
  - An issue counts on valid && ready.
  - A direction deasserts valid when issued == n_reps, or when outstanding (issued − completed) == MAX_OUTSTANDING.
  - valid may drop only after a handshake or on reset; fields remain stable while valid && !ready.
  - Issue and completion in the same cycle: outstanding is unchanged; issue is allowed if it was below the limit before the cycle.
  - Leave ISSUE for DRAIN when every enabled direction has issued n_reps.
- DRAIN: go to DONE when every enabled direction's completed count == n_reps.
- bench_done:
  - ctrl = 01 → rd_completed; ctrl = 10 → wr_completed; ctrl = 11 → min(rd_completed, wr_completed).
  - Registered, 1-cycle lag after the completion pulse.
- bench_timer:
  - Increments by 1 on every cycle in ISSUE or DRAIN (first increment is the cycle after req_accepted).
  - Holds in DONE and IDLE; cleared only on a new start or reset.
- DONE: holds outputs for 1 cycle, then returns to IDLE; a new start is accepted from IDLE only.
- Completion counters saturate at n_reps; excess cq pulses are ignored.

Optional Feature:
- Macro: BENCH_BEAT_CHECK_EN.
- When defined:
  - A 64-bit counter increments on mon_valid && mon_ready during ISSUE and DRAIN.
  - On entering DONE, beat_err is set if count != latched n_beats.
  - beat_err is sticky until the next start or reset.
- When undefined: counter absent, mon_* ignored, beat_err tied 0.

Decomposition:
- Package (perf_fpga_complicated_pkg): FSM state enum; ctrl bit indices (CTRL_RD=0, CTRL_WR=1); MAX_OUTSTANDING default; LEN_BITS/VADDR_BITS/PID_BITS come from lynxTypes.
- One sub-module, perf_fpga_bench_dir_issuer:
  - Instantiated twice (rd, wr).
  - Contains valid/ready issue logic, issued/completed/outstanding counters and the per-direction done flag.

Test Plan:
- ctrl=01, n_reps=4, len_A=4096, sq_rd_ready=1, cq 3 cycles after each issue → 4 rd issues, 0 wr, bench_done=4, FSM reaches DONE, timer>0 and then frozen.
- ctrl=11, n_reps=16, MAX_OUTSTANDING=8, cq withheld → exactly 8 issues per direction, valid low; release cq → all 16 issued, bench_done=16.
- ctrl=10, sq_wr_ready toggled randomly → fields stable while valid&&!ready, exactly n_reps handshakes.
- n_reps=0, ctrl=01 → req_accepted pulse, no sq valid, bench_done=0, timer=0.
- bench_reset mid-DRAIN with 3 outstanding → IDLE, counters 0, the 3 late cq pulses ignored (bench_done stays 0).
- BENCH_BEAT_CHECK_EN, n_beats=64, 63 mon beats → beat_err=1 in DONE; with 64 beats → beat_err=0.
